// File: rtl/boot_loader_rx.sv
// UART boot loader receive engine: parses ON/count/data/STP frames, writes
// little-endian words to instruction memory and releases the CPU on success.
module boot_loader_rx #(
  parameter logic [7:0]  ON_BYTE     = 8'hAA,
  parameter logic [7:0]  STP_BYTE    = 8'h55,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned TO_W        = 20
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        cpu_rst_o,
  output logic        boot_busy,
  output logic        boot_done,
  output logic        boot_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    STOP   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'd1);

  function automatic logic is_busy(input state_t s);
    case (s)
      CNT_LO, CNT_HI, DATA, WRITE, STOP: is_busy = 1'b1;
      default:                           is_busy = 1'b0;
    endcase
  endfunction

  state_t          state_r, state_s;
  logic [15:0]     cnt_r, cnt_s;
  logic [1:0]      idx_r, idx_s;
  logic [23:0]     asm_r, asm_s;
  logic            we_r, we_s;
  logic [31:0]     addr_r, addr_s;
  logic [31:0]     wdata_r, wdata_s;
  logic            cpu_rst_r, cpu_rst_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            err_r, err_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_s;
  logic            timeout_hit_s;
  logic [15:0]     cnt_full_s;

  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign cpu_rst_o = cpu_rst_r;
  assign boot_busy = busy_r;
  assign boot_done = done_r;
  assign boot_err  = err_r;

  // Next-state, datapath and output computation for the frame parser
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    asm_s     = asm_r;
    we_s      = we_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    cpu_rst_s = cpu_rst_r;
    done_s    = done_r;
    err_s     = err_r;
    cnt_full_s = {rx_data, cnt_r[7:0]};
    // An arriving byte always beats the timeout, so the hit needs a silent cycle
    timeout_hit_s = is_busy(state_r) && !rx_valid && (to_cnt_r == TO_LAST);

    if (timeout_hit_s) begin
      state_s = ERR;
      err_s   = 1'b1;
      we_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rx_valid && (rx_data == ON_BYTE)) begin
            state_s = CNT_LO;
            err_s   = 1'b0;
            addr_s  = BASE_ADDR;
          end else begin
            state_s = IDLE;
          end
        end
        CNT_LO: begin
          if (rx_valid) begin
            cnt_s[7:0] = rx_data;
            state_s    = CNT_HI;
          end else begin
            state_s = CNT_LO;
          end
        end
        CNT_HI: begin
          if (rx_valid) begin
            cnt_s   = cnt_full_s;
            idx_s   = 2'd0;
            state_s = (cnt_full_s == 16'd0) ? STOP : DATA;
          end else begin
            state_s = CNT_HI;
          end
        end
        DATA: begin
          if (rx_valid) begin
            idx_s = idx_r + 2'd1;
            case (idx_r)
              2'd0:    asm_s[7:0]   = rx_data;
              2'd1:    asm_s[15:8]  = rx_data;
              2'd2:    asm_s[23:16] = rx_data;
              default: begin
                we_s    = 1'b1;
                wdata_s = {rx_data, asm_r};
                state_s = WRITE;
              end
            endcase
          end else begin
            state_s = DATA;
          end
        end
        WRITE: begin
          // A byte during a pending write means the sender outran memory
          if (rx_valid) begin
            we_s    = 1'b0;
            err_s   = 1'b1;
            state_s = ERR;
          end else if (mem_ready) begin
            we_s    = 1'b0;
            addr_s  = addr_r + 32'd4;
            cnt_s   = cnt_r - 16'd1;
            idx_s   = 2'd0;
            state_s = (cnt_r == 16'd1) ? STOP : DATA;
          end else begin
            state_s = WRITE;
          end
        end
        STOP: begin
          if (rx_valid && (rx_data == STP_BYTE)) begin
            state_s   = DONE;
            cpu_rst_s = 1'b0;
            done_s    = 1'b1;
          end else if (rx_valid) begin
            state_s = ERR;
            err_s   = 1'b1;
          end else begin
            state_s = STOP;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        ERR: begin
          if (rx_valid && (rx_data == ON_BYTE)) begin
            state_s = CNT_LO;
            err_s   = 1'b0;
            addr_s  = BASE_ADDR;
          end else begin
            state_s = ERR;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    busy_s   = is_busy(state_s);
    to_cnt_s = (!is_busy(state_r) || rx_valid) ? '0 : (to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1});
  end

  // State and output registers
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      idx_r     <= 2'd0;
      asm_r     <= 24'd0;
      we_r      <= 1'b0;
      addr_r    <= BASE_ADDR;
      wdata_r   <= 32'd0;
      cpu_rst_r <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      to_cnt_r  <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      asm_r     <= asm_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      cpu_rst_r <= cpu_rst_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      to_cnt_r  <= to_cnt_s;
    end
  end

endmodule
